lockstep_checker: RTL and testbench
===================================

# lockstep_checker

Output comparator for the dual-core lockstep SoC. It sits directly downstream of both ibex cores. It samples each core's instruction-fetch and data-bus request fields every cycle and compares them with request-qualified masking. It then declares a sticky fault after a programmable run of consecutive mismatches, and records a fault count plus a snapshot of the first failing cycle for the testbench and any future error handler.

## Interface
- MISMATCH_THRESHOLD, 1: consecutive mismatching cycles required to enter FAULT (legal range 1..255).
- WARMUP_CYCLES, 2: cycles to skip after leaving DISABLED before comparisons count (0 allowed).
- CNT_WIDTH, 16: width of fault_count_o.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- enable_i  in  1  checker enable.
- clear_i  in  1  single-cycle pulse; clears error, counters and snapshot.
- c0_instr_req_i / c1_instr_req_i  in  1  instruction request, core 0 / core 1.
- c0_instr_addr_i / c1_instr_addr_i  in  32  fetch address.
- c0_data_req_i / c1_data_req_i  in  1  data request.
- c0_data_we_i / c1_data_we_i  in  1  data write enable.
- c0_data_be_i / c1_data_be_i  in  4  byte enables.
- c0_data_addr_i / c1_data_addr_i  in  32  data address.
- c0_data_wdata_i / c1_data_wdata_i  in  32  write data.
- mismatch_o  out  1  a qualified mismatch was sampled in the previous cycle, while CHECKING or FAULT.
- error_o  out  1  sticky fault flag; high exactly while state == FAULT.
- fault_count_o  out  CNT_WIDTH  total qualified mismatch cycles, saturating.
- fault_vector_o  out  7  field-mismatch bits captured at FAULT entry.
- fault_addr_o  out  32  c0_instr_addr_i of the first mismatch cycle of the run that caused FAULT.

## Operation
- Raw diff vector d[6:0], computed per cycle:
  - d[0] = instr_req differs.
  - d[1] = instr_addr differs, counted only if either instr_req is 1.
  - d[2] = data_req differs.
  - d[3] = data_we differs, counted only if either data_req is 1.
  - d[4] = data_be differs, counted only if either core has data_req & data_we.
  - d[5] = data_addr differs, counted only if either data_req is 1.
  - d[6] = data_wdata differs, counted only if either core has data_req & data_we.
- Stage 1 registers d into diff_q and c0_instr_addr_i into addr_q on every edge, independent of state.
- mismatch_o = (|diff_q) & (state ∈ {CHECKING, FAULT}).
- States:
  - DISABLED: entered from reset or when enable_i == 0. Stays here while enable_i == 0. Goes to WARMUP when enable_i == 1, or directly to CHECKING if WARMUP_CYCLES == 0.
  - WARMUP: a counter runs WARMUP_CYCLES cycles, then goes to CHECKING. Mismatches are ignored.
  - CHECKING: the run counter increments on mismatch_o and resets to 0 on a match.
    - The run's first-mismatch address (addr_q) is latched when the run counter goes 0→1.
    - When a mismatch makes run+1 == MISMATCH_THRESHOLD, go to FAULT and capture fault_vector_o = diff_q and fault_addr_o = the latched run address.
  - FAULT: sticky. Stays here regardless of enable_i until clear_i or rst_i.
- fault_count_o increments on every mismatch_o cycle in CHECKING or FAULT and saturates at all-ones.
- clear_i has priority over any same-cycle mismatch. It zeroes fault_count_o, the run counter, fault_vector_o and fault_addr_o. Next state is CHECKING if enable_i == 1, else DISABLED. The warmup is not repeated.
- enable_i falling in WARMUP or CHECKING goes to DISABLED and zeroes the run counter; fault_count_o is retained.

## Timing
- Reset values: mismatch_o 0, error_o 0, fault_count_o 0, fault_vector_o 0, fault_addr_o 0, state DISABLED, diff_q 0.
- Latency:
  - Inputs differing in cycle t produce mismatch_o = 1 in cycle t+1.
  - fault_count_o is updated in t+2.
  - With THRESHOLD = 1, error_o and the snapshot are valid in t+2.
  - In general, error_o rises 2 cycles after the THRESHOLD-th consecutive mismatching input cycle.
- A mismatch in the last WARMUP cycle is not counted. The first counted input cycle is the one sampled on the edge that enters CHECKING.
- rst_i asserted mid-operation, including in FAULT, returns everything to reset values on the next edge.
- Counter saturation: at all-ones, further mismatches leave fault_count_o unchanged with no wrap.

## Test plan
- Identical core streams for 200 cycles, enable_i = 1 → mismatch_o never 1, error_o 0, fault_count_o 0.
- THRESHOLD = 1: c1_data_wdata_i = c0 ^ 32'h1 with data_req = 1 and data_we = 1 in cycle t, c0_instr_addr_i = 32'h80 → mismatch_o = 1 at t+1; error_o = 1, fault_vector_o = 7'b1000000, fault_addr_o = 32'h80, fault_count_o = 1 at t+2.
- Masking: data_wdata differs with data_we = 0, and instr_addr differs with instr_req = 0 on both cores → no mismatch_o, count stays 0.
- THRESHOLD = 3: two mismatch cycles, one match, two mismatches → error_o stays 0, fault_count_o = 4. A third consecutive mismatch then gives error_o = 1.
- CNT_WIDTH = 4 with 20 mismatch cycles → fault_count_o saturates at 4'hF. clear_i together with a mismatch → count 0, error_o 0, state CHECKING.
- rst_i pulsed while in FAULT → all outputs 0 on the next cycle. enable_i = 1 then yields no counted mismatch during the first WARMUP_CYCLES = 2 cycles.

Source files
------------

// File: rtl/lockstep_checker.sv
// Lockstep output comparator for two ibex cores: masks, compares and
// registers per-field request diffs, then runs a DISABLED/WARMUP/CHECKING/FAULT FSM.
// Ports: clk_i, rst_i (sync, active-high), enable_i, clear_i;
//   c0_*/c1_* instruction- and data-bus request fields of each core;
//   mismatch_o, error_o, fault_count_o, fault_vector_o, fault_addr_o.
module lockstep_checker #(
    parameter int unsigned MISMATCH_THRESHOLD = 1,
    parameter int unsigned WARMUP_CYCLES      = 2,
    parameter int unsigned CNT_WIDTH          = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic                 clear_i,
    input  logic                 c0_instr_req_i,
    input  logic                 c1_instr_req_i,
    input  logic [31:0]          c0_instr_addr_i,
    input  logic [31:0]          c1_instr_addr_i,
    input  logic                 c0_data_req_i,
    input  logic                 c1_data_req_i,
    input  logic                 c0_data_we_i,
    input  logic                 c1_data_we_i,
    input  logic [3:0]           c0_data_be_i,
    input  logic [3:0]           c1_data_be_i,
    input  logic [31:0]          c0_data_addr_i,
    input  logic [31:0]          c1_data_addr_i,
    input  logic [31:0]          c0_data_wdata_i,
    input  logic [31:0]          c1_data_wdata_i,
    output logic                 mismatch_o,
    output logic                 error_o,
    output logic [CNT_WIDTH-1:0] fault_count_o,
    output logic [6:0]           fault_vector_o,
    output logic [31:0]          fault_addr_o
);

    typedef enum logic [1:0] {
        S_DISABLED,
        S_WARMUP,
        S_CHECKING,
        S_FAULT
    } state_t;

    localparam logic [7:0]  THR     = 8'(MISMATCH_THRESHOLD);
    // Only consulted when WARMUP_CYCLES > 0.
    localparam logic [31:0] WU_LAST = 32'(WARMUP_CYCLES) - 32'd1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // Qualifiers: a field is only compared when some core actually uses it.
    logic any_ireq;
    logic any_dreq;
    logic any_wr;
    logic [6:0] d;

    assign any_ireq = c0_instr_req_i | c1_instr_req_i;
    assign any_dreq = c0_data_req_i | c1_data_req_i;
    assign any_wr   = (c0_data_req_i & c0_data_we_i) |
                      (c1_data_req_i & c1_data_we_i);

    assign d[0] = c0_instr_req_i ^ c1_instr_req_i;
    assign d[1] = any_ireq & (c0_instr_addr_i != c1_instr_addr_i);
    assign d[2] = c0_data_req_i ^ c1_data_req_i;
    assign d[3] = any_dreq & (c0_data_we_i ^ c1_data_we_i);
    assign d[4] = any_wr & (c0_data_be_i != c1_data_be_i);
    assign d[5] = any_dreq & (c0_data_addr_i != c1_data_addr_i);
    assign d[6] = any_wr & (c0_data_wdata_i != c1_data_wdata_i);

    logic [6:0]  diff_q;
    logic [31:0] addr_q;

    // Stage 1: sample diffs regardless of FSM state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            diff_q <= '0;
            addr_q <= '0;
        end else begin
            diff_q <= d;
            addr_q <= c0_instr_addr_i;
        end
    end

    state_t               state_q, state_d;
    logic [7:0]           run_q, run_d;
    logic [31:0]          wcnt_q, wcnt_d;
    logic [31:0]          raddr_q, raddr_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [6:0]           vec_q, vec_d;
    logic [31:0]          faddr_q, faddr_d;
    logic                 mm;

    assign mm = (|diff_q) &
                ((state_q == S_CHECKING) | (state_q == S_FAULT));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_DISABLED;
            run_q   <= '0;
            wcnt_q  <= '0;
            raddr_q <= '0;
            cnt_q   <= '0;
            vec_q   <= '0;
            faddr_q <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            wcnt_q  <= wcnt_d;
            raddr_q <= raddr_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            faddr_q <= faddr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        wcnt_d  = wcnt_q;
        raddr_d = raddr_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        faddr_d = faddr_q;

        if (mm && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_ONE;
        end

        if (clear_i) begin
            // Clear wins over a same-cycle mismatch; warmup is skipped.
            cnt_d   = '0;
            run_d   = '0;
            raddr_d = '0;
            vec_d   = '0;
            faddr_d = '0;
            state_d = enable_i ? S_CHECKING : S_DISABLED;
        end else begin
            unique case (state_q)
                S_DISABLED: begin
                    run_d = '0;
                    if (enable_i) begin
                        wcnt_d = '0;
                        if (WARMUP_CYCLES == 0) begin
                            state_d = S_CHECKING;
                        end else begin
                            state_d = S_WARMUP;
                        end
                    end
                end
                S_WARMUP: begin
                    if (!enable_i) begin
                        state_d = S_DISABLED;
                        run_d   = '0;
                    end else if (wcnt_q == WU_LAST) begin
                        state_d = S_CHECKING;
                    end else begin
                        wcnt_d = wcnt_q + 32'd1;
                    end
                end
                S_CHECKING: begin
                    if (!enable_i) begin
                        state_d = S_DISABLED;
                        run_d   = '0;
                    end else if (mm) begin
                        run_d = run_q + 8'd1;
                        if (run_q == 8'd0) begin
                            raddr_d = addr_q;
                        end
                        if ((run_q + 8'd1) == THR) begin
                            state_d = S_FAULT;
                            vec_d   = diff_q;
                            faddr_d = (run_q == 8'd0) ? addr_q : raddr_q;
                        end
                    end else begin
                        run_d = '0;
                    end
                end
                S_FAULT: begin
                    state_d = S_FAULT;
                end
            endcase
        end
    end

    assign mismatch_o     = mm;
    assign error_o        = (state_q == S_FAULT);
    assign fault_count_o  = cnt_q;
    assign fault_vector_o = vec_q;
    assign fault_addr_o   = faddr_q;

endmodule

// File: tb/tb_lockstep_checker.sv
// Directed bench for lockstep_checker: three instances with different
// threshold / warmup / counter-width parameters share one stimulus stream.
module tb_lockstep_checker;

    logic clk;
    logic rst;
    logic en;
    logic clr;

    logic        c0_ireq, c1_ireq;
    logic [31:0] c0_iaddr, c1_iaddr;
    logic        c0_dreq, c1_dreq;
    logic        c0_we, c1_we;
    logic [3:0]  c0_be, c1_be;
    logic [31:0] c0_daddr, c1_daddr;
    logic [31:0] c0_wdata, c1_wdata;

    logic        a_mm, a_err;
    logic [15:0] a_cnt;
    logic [6:0]  a_vec;
    logic [31:0] a_addr;

    logic        b_mm, b_err;
    logic [15:0] b_cnt;
    logic [6:0]  b_vec;
    logic [31:0] b_addr;

    logic        c_mm, c_err;
    logic [3:0]  c_cnt;
    logic [6:0]  c_vec;
    logic [31:0] c_addr;

    int nvec;
    int nfail;

    lockstep_checker u_a (
        .clk_i(clk), .rst_i(rst), .enable_i(en), .clear_i(clr),
        .c0_instr_req_i(c0_ireq), .c1_instr_req_i(c1_ireq),
        .c0_instr_addr_i(c0_iaddr), .c1_instr_addr_i(c1_iaddr),
        .c0_data_req_i(c0_dreq), .c1_data_req_i(c1_dreq),
        .c0_data_we_i(c0_we), .c1_data_we_i(c1_we),
        .c0_data_be_i(c0_be), .c1_data_be_i(c1_be),
        .c0_data_addr_i(c0_daddr), .c1_data_addr_i(c1_daddr),
        .c0_data_wdata_i(c0_wdata), .c1_data_wdata_i(c1_wdata),
        .mismatch_o(a_mm), .error_o(a_err), .fault_count_o(a_cnt),
        .fault_vector_o(a_vec), .fault_addr_o(a_addr)
    );

    lockstep_checker #(.MISMATCH_THRESHOLD(3)) u_b (
        .clk_i(clk), .rst_i(rst), .enable_i(en), .clear_i(clr),
        .c0_instr_req_i(c0_ireq), .c1_instr_req_i(c1_ireq),
        .c0_instr_addr_i(c0_iaddr), .c1_instr_addr_i(c1_iaddr),
        .c0_data_req_i(c0_dreq), .c1_data_req_i(c1_dreq),
        .c0_data_we_i(c0_we), .c1_data_we_i(c1_we),
        .c0_data_be_i(c0_be), .c1_data_be_i(c1_be),
        .c0_data_addr_i(c0_daddr), .c1_data_addr_i(c1_daddr),
        .c0_data_wdata_i(c0_wdata), .c1_data_wdata_i(c1_wdata),
        .mismatch_o(b_mm), .error_o(b_err), .fault_count_o(b_cnt),
        .fault_vector_o(b_vec), .fault_addr_o(b_addr)
    );

    lockstep_checker #(
        .MISMATCH_THRESHOLD(1),
        .WARMUP_CYCLES(0),
        .CNT_WIDTH(4)
    ) u_c (
        .clk_i(clk), .rst_i(rst), .enable_i(en), .clear_i(clr),
        .c0_instr_req_i(c0_ireq), .c1_instr_req_i(c1_ireq),
        .c0_instr_addr_i(c0_iaddr), .c1_instr_addr_i(c1_iaddr),
        .c0_data_req_i(c0_dreq), .c1_data_req_i(c1_dreq),
        .c0_data_we_i(c0_we), .c1_data_we_i(c1_we),
        .c0_data_be_i(c0_be), .c1_data_be_i(c1_be),
        .c0_data_addr_i(c0_daddr), .c1_data_addr_i(c1_daddr),
        .c0_data_wdata_i(c0_wdata), .c1_data_wdata_i(c1_wdata),
        .mismatch_o(c_mm), .error_o(c_err), .fault_count_o(c_cnt),
        .fault_vector_o(c_vec), .fault_addr_o(c_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic mirror();
        c1_ireq  = c0_ireq;
        c1_iaddr = c0_iaddr;
        c1_dreq  = c0_dreq;
        c1_we    = c0_we;
        c1_be    = c0_be;
        c1_daddr = c0_daddr;
        c1_wdata = c0_wdata;
    endtask

    task automatic base(input logic [31:0] addr);
        c0_ireq  = 1'b1;
        c0_iaddr = addr;
        c0_dreq  = 1'b0;
        c0_we    = 1'b0;
        c0_be    = 4'h0;
        c0_daddr = 32'h0;
        c0_wdata = 32'h0;
        mirror();
    endtask

    initial begin
        nvec  = 0;
        nfail = 0;
        rst   = 1'b1;
        en    = 1'b0;
        clr   = 1'b0;
        base(32'h0);
        step();
        step();

        chk("rst_mm",   {31'b0, a_mm}, 32'h0);
        chk("rst_err",  {31'b0, a_err}, 32'h0);
        chk("rst_cnt",  {16'b0, a_cnt}, 32'h0);
        chk("rst_vec",  {25'b0, a_vec}, 32'h0);
        chk("rst_addr", a_addr, 32'h0);

        // Identical streams.
        rst = 1'b0;
        en  = 1'b1;
        for (int i = 0; i < 200; i++) begin
            c0_ireq  = 1'($urandom);
            c0_iaddr = $urandom;
            c0_dreq  = 1'($urandom);
            c0_we    = 1'($urandom);
            c0_be    = 4'($urandom);
            c0_daddr = $urandom;
            c0_wdata = $urandom;
            mirror();
            step();
            chk("ident_mm", {31'b0, a_mm}, 32'h0);
        end
        base(32'h0);
        step();
        chk("ident_cnt", {16'b0, a_cnt}, 32'h0);
        chk("ident_err", {31'b0, a_err}, 32'h0);

        // Masked differences.
        base(32'h10);
        c0_ireq  = 1'b0;
        c1_ireq  = 1'b0;
        c1_iaddr = 32'h14;
        c0_we    = 1'b1;
        c1_be    = 4'h5;
        c1_daddr = 32'h99;
        c1_wdata = 32'h1234;
        step();
        chk("mask_noreq", {31'b0, a_mm}, 32'h0);
        base(32'h40);
        c0_dreq  = 1'b1;
        c1_dreq  = 1'b1;
        c0_be    = 4'hF;
        c1_be    = 4'h3;
        c1_wdata = 32'hFFFF;
        step();
        chk("mask_nowe", {31'b0, a_mm}, 32'h0);
        base(32'h44);
        step();
        chk("mask_cnt", {16'b0, a_cnt}, 32'h0);

        // Threshold 1: wdata mismatch at fetch addr 0x80.
        base(32'h80);
        c0_dreq  = 1'b1;
        c0_we    = 1'b1;
        c0_be    = 4'hF;
        c0_daddr = 32'h1000;
        c0_wdata = 32'hDEADBEEF;
        mirror();
        c1_wdata = 32'hDEADBEEE;
        step();
        chk("t1_mm", {31'b0, a_mm}, 32'h1);
        chk("t1_err_early", {31'b0, a_err}, 32'h0);
        base(32'h100);
        step();
        chk("t1_err",  {31'b0, a_err}, 32'h1);
        chk("t1_vec",  {25'b0, a_vec}, 32'h40);
        chk("t1_addr", a_addr, 32'h80);
        chk("t1_cnt",  {16'b0, a_cnt}, 32'h1);

        // FAULT is sticky across enable low.
        en = 1'b0;
        step();
        step();
        chk("sticky_err", {31'b0, a_err}, 32'h1);

        // Reset while in FAULT.
        rst = 1'b1;
        step();
        chk("frst_mm",   {31'b0, a_mm}, 32'h0);
        chk("frst_err",  {31'b0, a_err}, 32'h0);
        chk("frst_cnt",  {16'b0, a_cnt}, 32'h0);
        chk("frst_vec",  {25'b0, a_vec}, 32'h0);
        chk("frst_addr", a_addr, 32'h0);

        // Warmup ignores mismatches.
        rst = 1'b0;
        en  = 1'b1;
        base(32'h200);
        c1_iaddr = 32'h204;
        step();
        chk("wu1_mm", {31'b0, a_mm}, 32'h0);
        step();
        chk("wu2_mm", {31'b0, a_mm}, 32'h0);
        base(32'h208);
        step();
        chk("wu3_mm", {31'b0, a_mm}, 32'h0);
        step();
        chk("wu_cnt", {16'b0, a_cnt}, 32'h0);
        chk("wu_err", {31'b0, a_err}, 32'h0);
        base(32'h20C);
        c1_iaddr = 32'h0;
        step();
        chk("post_wu_mm", {31'b0, a_mm}, 32'h1);
        base(32'h210);
        step();
        chk("post_wu_err", {31'b0, a_err}, 32'h1);

        // Threshold 3 on instance b.
        rst = 1'b1;
        base(32'h0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step();
        base(32'h100); c1_iaddr = 32'h1;   step();
        base(32'h110); c1_iaddr = 32'h1;   step();
        base(32'h120);                     step();
        base(32'h300); c1_iaddr = 32'h1;   step();
        base(32'h310); c1_iaddr = 32'h1;   step();
        base(32'h320);
        c0_dreq = 1'b1;
        c0_we   = 1'b1;
        c1_we   = 1'b1;
        c0_be   = 4'hF;
        c1_be   = 4'h1;
        step();
        chk("t3_cnt4", {16'b0, b_cnt}, 32'h4);
        chk("t3_err0", {31'b0, b_err}, 32'h0);
        base(32'h330);
        step();
        chk("t3_err1", {31'b0, b_err}, 32'h1);
        chk("t3_cnt5", {16'b0, b_cnt}, 32'h5);
        chk("t3_vec",  {25'b0, b_vec}, 32'h14);
        chk("t3_addr", b_addr, 32'h300);

        // Saturation and clear on instance c.
        rst = 1'b1;
        base(32'h0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step();
        for (int i = 0; i < 20; i++) begin
            base(32'h400 + 32'(i * 4));
            c1_iaddr = c0_iaddr + 32'h1;
            step();
        end
        base(32'h0);
        step();
        step();
        chk("sat_cnt", {28'b0, c_cnt}, 32'hF);
        chk("sat_err", {31'b0, c_err}, 32'h1);
        chk("sat_vec", {25'b0, c_vec}, 32'h02);
        base(32'h480);
        c1_iaddr = 32'h0;
        step();
        chk("clr_pre_mm", {31'b0, c_mm}, 32'h1);
        base(32'h484);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_cnt",  {28'b0, c_cnt}, 32'h0);
        chk("clr_err",  {31'b0, c_err}, 32'h0);
        chk("clr_vec",  {25'b0, c_vec}, 32'h0);
        chk("clr_addr", c_addr, 32'h0);
        base(32'h500);
        c1_iaddr = 32'h0;
        step();
        chk("clr_chk_mm", {31'b0, c_mm}, 32'h1);
        base(32'h504);
        step();
        chk("clr_chk_err",  {31'b0, c_err}, 32'h1);
        chk("clr_chk_cnt",  {28'b0, c_cnt}, 32'h1);
        chk("clr_chk_addr", c_addr, 32'h500);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
